ofdm_cp_remover: RTL and testbench



---
 rtl/ofdm_rx_pkg.sv | 25 ++
 rtl/ofdm_sample_ram.sv | 35 +++
 rtl/ofdm_cp_remover.sv | 194 +++++++++++++++++++
 tb/tb_ofdm_cp_remover.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// Shared types and helpers for the OFDM receive front end: sample width,
// input state encoding, fftpts encoding and FIFO pointer sizing.
package ofdm_rx_pkg;

    localparam int SAMPLE_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_PASS = 2'd2,
        ST_DROP = 2'd3
    } in_state_e;

    function automatic logic [7:0] fftpts_enc(input int n_fft);
        logic [31:0] n_v;
        n_v = n_fft;
        return n_v[7:0];
    endfunction

    // One extra bit beyond the address so full and empty stay distinguishable.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofdm_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Storage is deliberately left without reset.
module ofdm_sample_ram
    import ofdm_rx_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 2 * SAMPLE_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/ofdm_cp_remover.sv
// Strips the cyclic prefix, buffers useful samples behind a commit pointer and
// forwards only complete N_FFT frames to the FFT sink as Avalon-ST packets.
module ofdm_cp_remover #(
    parameter int N_FFT    = 128,
    parameter int CP_LEN   = 32,
    parameter int SAMPLE_W = ofdm_rx_pkg::SAMPLE_W,
    parameter int DEPTH    = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic                in_sym_start,
    input  logic [SAMPLE_W-1:0] in_real,
    input  logic [SAMPLE_W-1:0] in_imag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sop,
    output logic                out_eop,
    output logic [SAMPLE_W-1:0] out_real,
    output logic [SAMPLE_W-1:0] out_imag,
    output logic [1:0]          out_error,
    output logic [7:0]          fftpts,
    output logic                inverse,
    output logic                overflow,
    output logic                resync,
    input  logic                clr_status
);
    import ofdm_rx_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int CW = $clog2(CP_LEN + 1);
    localparam int NW = $clog2(N_FFT + 1);
    localparam int DW = 2 * SAMPLE_W;

    in_state_e     state_q;
    logic [CW-1:0] cp_cnt_q;
    logic [NW-1:0] sym_cnt_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] commit_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          overflow_q;
    logic          resync_q;

    logic [PW-1:0] free_s;
    logic          room_s;
    logic          cp_done_s;
    logic [NW-1:0] cnt_s;
    logic          last_s;
    logic          wr_en_s;

    logic          ram_vld_q;
    logic [DW-1:0] ram_rd_s;
    logic          rd_en_s;
    logic          out_load_s;
    logic [NW-1:0] out_cnt_q;
    logic          out_valid_q;
    logic          out_sop_q;
    logic          out_eop_q;
    logic [SAMPLE_W-1:0] out_real_q;
    logic [SAMPLE_W-1:0] out_imag_q;

    assign free_s    = PW'(DEPTH) - (wr_ptr_q - rd_ptr_q);
    assign room_s    = (free_s >= PW'(N_FFT));
    assign cp_done_s = (cp_cnt_q == CW'(CP_LEN));
    // The first useful sample arrives while still in SKIP, so it is sample 0.
    assign cnt_s     = (state_q == ST_SKIP) ? '0 : sym_cnt_q;
    assign last_s    = (cnt_s == NW'(N_FFT - 1));
    assign wr_en_s   = in_valid && !in_sym_start &&
                       ((state_q == ST_PASS) || ((state_q == ST_SKIP) && cp_done_s && room_s));

    // Input state machine: CP skip, commit of whole symbols, drop and abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cp_cnt_q     <= '0;
            sym_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            overflow_q   <= 1'b0;
            resync_q     <= 1'b0;
        end else begin
            if (clr_status) begin
                overflow_q <= 1'b0;
                resync_q   <= 1'b0;
            end
            if (in_valid) begin
                if (in_sym_start) begin
                    state_q   <= ST_SKIP;
                    cp_cnt_q  <= CW'(1);
                    sym_cnt_q <= '0;
                    if (state_q != ST_IDLE) begin
                        wr_ptr_q <= commit_ptr_q;
                        resync_q <= 1'b1;
                    end
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            state_q <= ST_IDLE;
                        end
                        ST_SKIP, ST_PASS: begin
                            if ((state_q == ST_SKIP) && !cp_done_s) begin
                                cp_cnt_q <= cp_cnt_q + CW'(1);
                            end else if (wr_en_s) begin
                                wr_ptr_q <= wr_ptr_q + PW'(1);
                                if (last_s) begin
                                    commit_ptr_q <= wr_ptr_q + PW'(1);
                                    state_q      <= ST_IDLE;
                                    sym_cnt_q    <= '0;
                                end else begin
                                    state_q   <= ST_PASS;
                                    sym_cnt_q <= cnt_s + NW'(1);
                                end
                            end else begin
                                overflow_q <= 1'b1;
                                state_q    <= last_s ? ST_IDLE : ST_DROP;
                                sym_cnt_q  <= last_s ? '0 : cnt_s + NW'(1);
                            end
                        end
                        ST_DROP: begin
                            state_q   <= last_s ? ST_IDLE : ST_DROP;
                            sym_cnt_q <= last_s ? '0 : cnt_s + NW'(1);
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    ofdm_sample_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({in_real, in_imag}),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_rd_s)
    );

    // Two-stage show-ahead: RAM output stage feeds the output register.
    assign out_load_s = ram_vld_q && (!out_valid_q || out_ready);
    assign rd_en_s    = (rd_ptr_q != commit_ptr_q) && (!ram_vld_q || out_load_s);

    // Read side: pointer, RAM-stage valid, output register and frame counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            ram_vld_q   <= 1'b0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
        end else begin
            if (rd_en_s) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                ram_vld_q <= 1'b1;
            end else if (out_load_s) begin
                ram_vld_q <= 1'b0;
            end
            if (out_load_s) begin
                out_valid_q <= 1'b1;
                out_real_q  <= ram_rd_s[DW-1:SAMPLE_W];
                out_imag_q  <= ram_rd_s[SAMPLE_W-1:0];
                out_sop_q   <= (out_cnt_q == '0);
                out_eop_q   <= (out_cnt_q == NW'(N_FFT - 1));
                out_cnt_q   <= (out_cnt_q == NW'(N_FFT - 1)) ? '0 : out_cnt_q + NW'(1);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_sop_q   <= 1'b0;
                out_eop_q   <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign out_error = 2'b00;
    assign fftpts    = fftpts_enc(N_FFT);
    assign inverse   = 1'b0;
    assign overflow  = overflow_q;
    assign resync    = resync_q;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Directed bench for ofdm_cp_remover: a DEPTH=256 instance for the main
// scenarios and a DEPTH=128 instance for the pointer-wrap scenario.
`timescale 1ns/1ps
module tb_ofdm_cp_remover;

    localparam int N  = 128;
    localparam int CP = 32;
    localparam int SW = 18;

    typedef struct packed {
        logic [SW-1:0] re;
        logic [SW-1:0] im;
        logic          sop;
        logic          eop;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, in_valid, in_sym_start, out_ready, clr_status;
    logic [SW-1:0] in_real, in_imag;

    logic a_valid, a_sop, a_eop, a_inverse, a_overflow, a_resync;
    logic [SW-1:0] a_real, a_imag;
    logic [1:0] a_error;
    logic [7:0] a_fftpts;
    logic b_valid, b_sop, b_eop, b_inverse, b_overflow, b_resync;
    logic [SW-1:0] b_real, b_imag;
    logic [1:0] b_error;
    logic [7:0] b_fftpts;

    ofdm_cp_remover #(.N_FFT(N), .CP_LEN(CP), .SAMPLE_W(SW), .DEPTH(256)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sym_start(in_sym_start),
        .in_real(in_real), .in_imag(in_imag), .out_valid(a_valid), .out_ready(out_ready),
        .out_sop(a_sop), .out_eop(a_eop), .out_real(a_real), .out_imag(a_imag),
        .out_error(a_error), .fftpts(a_fftpts), .inverse(a_inverse),
        .overflow(a_overflow), .resync(a_resync), .clr_status(clr_status));

    ofdm_cp_remover #(.N_FFT(N), .CP_LEN(CP), .SAMPLE_W(SW), .DEPTH(128)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sym_start(in_sym_start),
        .in_real(in_real), .in_imag(in_imag), .out_valid(b_valid), .out_ready(out_ready),
        .out_sop(b_sop), .out_eop(b_eop), .out_real(b_real), .out_imag(b_imag),
        .out_error(b_error), .fftpts(b_fftpts), .inverse(b_inverse),
        .overflow(b_overflow), .resync(b_resync), .clr_status(clr_status));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_valid_cyc = -1;
    int   stall_err_a = 0;
    logic mon_en = 1'b0;
    logic rdy_rand = 1'b0;
    logic rdy_val = 1'b1;
    logic a_hold = 1'b0;
    rec_t a_prev;
    rec_t qa[$];
    rec_t qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? ($urandom_range(99) < 30) : rdy_val;
        end
    end

    // Collects accepted samples and flags any change while a sample is stalled.
    always @(negedge clk) begin
        rec_t cur;
        cur = {a_real, a_imag, a_sop, a_eop};
        if (!mon_en) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold && (!a_valid || cur !== a_prev)) stall_err_a++;
            a_hold = a_valid && !out_ready;
            a_prev = cur;
            if (a_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (a_valid && out_ready) qa.push_back(cur);
            if (b_valid && out_ready) qb.push_back({b_real, b_imag, b_sop, b_eop});
        end
    end

    function automatic int stream_bad(input rec_t q[$], input int bases[$]);
        int bad = 0;
        int j = 0;
        int idx;
        if (q.size() != bases.size() * N) bad++;
        foreach (bases[p]) begin
            for (int k = 0; k < N; k++) begin
                if (j < q.size()) begin
                    idx = bases[p] + k;
                    if (q[j].re !== SW'(idx) || q[j].im !== (SW'(idx) ^ {SW{1'b1}}) ||
                        q[j].sop !== (k == 0) || q[j].eop !== (k == N - 1)) bad++;
                end
                j++;
            end
        end
        return bad;
    endfunction

    task automatic do_reset();
        mon_en = 1'b0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_sym_start = 1'b0;
        in_real = '0;
        in_imag = '0;
        clr_status = 1'b0;
        rdy_rand = 1'b0;
        rdy_val = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        qa.delete();
        qb.delete();
        first_valid_cyc = -1;
        stall_err_a = 0;
        mon_en = 1'b1;
    endtask

    task automatic drive_run(input int base, input int n, input bit start);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_sym_start = start && (i == 0);
            in_real = SW'(base + i);
            in_imag = SW'(base + i) ^ {SW{1'b1}};
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sym_start = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_q(input bit use_b, input int n, input int budget);
        int c = 0;
        while (((use_b ? qb.size() : qa.size()) < n) && (c < budget)) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({a_valid, a_sop, a_eop, a_overflow, a_resync, a_inverse} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {a_valid, a_sop, a_eop, a_overflow, a_resync, a_inverse});
        end
        checks++;
        if ({a_real, a_imag} !== {2*SW{1'b0}}) begin
            errors++;
            $display("FAIL reset_data: got %0h/%0h expected 0/0", a_real, a_imag);
        end
        checks++;
        if (a_fftpts !== 8'd128) begin
            errors++;
            $display("FAIL fftpts: got %0d expected 128", a_fftpts);
        end
        checks++;
        if (a_error !== 2'b00 || b_error !== 2'b00) begin
            errors++;
            $display("FAIL out_error: got %b/%b expected 00", a_error, b_error);
        end
    endtask

    task automatic test_nominal();
        int bases[$];
        int last_cyc;
        do_reset();
        drive_run(0, 160, 1'b1);
        last_cyc = cyc;
        drive_run(160, 160, 1'b1);
        drive_run(320, 160, 1'b1);
        idle(5);
        wait_q(1'b0, 3 * N, 1000);
        idle(20);
        bases.push_back(32);
        bases.push_back(192);
        bases.push_back(352);
        checks++;
        if (qa.size() !== 3 * N) begin
            errors++;
            $display("FAIL nominal_count: got %0d expected %0d", qa.size(), 3 * N);
        end
        checks++;
        if (stream_bad(qa, bases) !== 0) begin
            errors++;
            $display("FAIL nominal_data: got %0d bad samples expected 0", stream_bad(qa, bases));
        end
        // Commit edge plus two register stages after the last accepted sample.
        checks++;
        if (first_valid_cyc - last_cyc !== 3) begin
            errors++;
            $display("FAIL nominal_latency: got %0d expected 3", first_valid_cyc - last_cyc);
        end
    endtask

    task automatic test_backpressure();
        int bases[$];
        do_reset();
        rdy_rand = 1'b1;
        for (int s = 0; s < 3; s++) begin
            drive_run(1000 + s * 160, 160, 1'b1);
            idle(400);
            bases.push_back(1032 + s * 160);
        end
        wait_q(1'b0, 3 * N, 3000);
        rdy_rand = 1'b0;
        rdy_val = 1'b1;
        idle(20);
        checks++;
        if (stream_bad(qa, bases) !== 0) begin
            errors++;
            $display("FAIL bp_data: got %0d bad (size %0d) expected 0", stream_bad(qa, bases), qa.size());
        end
        checks++;
        if (stall_err_a !== 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_err_a);
        end
        checks++;
        if (a_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_overflow: got %b expected 0", a_overflow);
        end
    endtask

    task automatic test_overflow();
        int bases[$];
        do_reset();
        rdy_val = 1'b0;
        for (int s = 0; s < 4; s++) drive_run(2000 + s * 160, 160, 1'b1);
        idle(5);
        checks++;
        if ({a_overflow, a_resync} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_flags: got %b expected 10", {a_overflow, a_resync});
        end
        checks++;
        if (qa.size() !== 0) begin
            errors++;
            $display("FAIL ovf_stalled: got %0d transfers expected 0", qa.size());
        end
        rdy_val = 1'b1;
        wait_q(1'b0, 2 * N, 600);
        idle(200);
        bases.push_back(2032);
        bases.push_back(2192);
        checks++;
        if (stream_bad(qa, bases) !== 0) begin
            errors++;
            $display("FAIL ovf_data: got %0d bad (size %0d) expected 0", stream_bad(qa, bases), qa.size());
        end
        checks++;
        if (stall_err_a !== 0) begin
            errors++;
            $display("FAIL ovf_stable: got %0d changes while stalled expected 0", stall_err_a);
        end
        @(posedge clk);
        #1 clr_status = 1'b1;
        @(posedge clk);
        #1 clr_status = 1'b0;
        @(negedge clk);
        checks++;
        if (a_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", a_overflow);
        end
    endtask

    task automatic test_resync();
        int bases[$];
        do_reset();
        drive_run(3000, CP + 50, 1'b1);
        drive_run(3082, 160, 1'b1);
        idle(5);
        wait_q(1'b0, N, 500);
        idle(200);
        bases.push_back(3114);
        checks++;
        if ({a_resync, a_overflow} !== 2'b10) begin
            errors++;
            $display("FAIL resync_flags: got %b expected 10", {a_resync, a_overflow});
        end
        checks++;
        if (stream_bad(qa, bases) !== 0) begin
            errors++;
            $display("FAIL resync_data: got %0d bad (size %0d) expected 0", stream_bad(qa, bases), qa.size());
        end
    endtask

    task automatic test_reset_mid();
        int bases[$];
        int n;
        do_reset();
        drive_run(4000, 160, 1'b1);
        idle(1);
        wait_q(1'b0, 60, 400);
        @(posedge clk);
        #1;
        n = qa.size();
        checks++;
        if (a_real !== SW'(4032 + n) || a_valid !== 1'b1 || n < 60) begin
            errors++;
            $display("FAIL mid_sample: got %0d valid %b expected %0d valid 1 (n=%0d)", a_real, a_valid, 4032 + n, n);
        end
        mon_en = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_valid, a_sop, a_eop} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_out: got %b expected 000", {a_valid, a_sop, a_eop});
        end
        qa.delete();
        mon_en = 1'b1;
        idle(50);
        checks++;
        if (qa.size() !== 0) begin
            errors++;
            $display("FAIL mid_empty: got %0d transfers expected 0", qa.size());
        end
        drive_run(4200, 160, 1'b1);
        idle(5);
        wait_q(1'b0, N, 500);
        idle(20);
        bases.push_back(4232);
        checks++;
        if (stream_bad(qa, bases) !== 0) begin
            errors++;
            $display("FAIL mid_next: got %0d bad (size %0d) expected 0", stream_bad(qa, bases), qa.size());
        end
    endtask

    task automatic test_wrap();
        int bases[$];
        do_reset();
        for (int s = 0; s < 20; s++) begin
            drive_run(5000 + s * 160, 160, 1'b1);
            idle(150);
            bases.push_back(5032 + s * 160);
        end
        wait_q(1'b1, 20 * N, 1000);
        idle(20);
        checks++;
        if (qb.size() !== 20 * N) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected %0d", qb.size(), 20 * N);
        end
        checks++;
        if (stream_bad(qb, bases) !== 0) begin
            errors++;
            $display("FAIL wrap_data: got %0d bad samples expected 0", stream_bad(qb, bases));
        end
        checks++;
        if ({b_overflow, b_resync} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_flags: got %b expected 00", {b_overflow, b_resync});
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_overflow();
        test_resync();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
